// File: rtl/vec_mem_stage.sv
// vec_mem_stage: serializes 16-lane vector loads/stores onto a single-port 32-bit memory,
// stalling upstream while in flight and emitting a one-cycle write-back beat.
module vec_mem_stage #(
    parameter int LANES = 16,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      ValidM,
    input  logic [LANES-1:0][DW-1:0]  ALUResultM,
    input  logic [LANES-1:0][DW-1:0]  WriteDataM,
    input  logic                      RegWriteM,
    input  logic                      MemtoRegM,
    input  logic                      MemWriteM,
    input  logic [3:0]                WA3M,
    output logic                      StallM,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [AW-1:0]             mem_addr,
    output logic [DW-1:0]             mem_wdata,
    input  logic [DW-1:0]             mem_rdata,
    input  logic                      mem_ready,
    output logic                      ValidW,
    output logic [LANES-1:0][DW-1:0]  ALUOutW,
    output logic [LANES-1:0][DW-1:0]  ReadDataW,
    output logic                      RegWriteW,
    output logic                      MemtoRegW,
    output logic [3:0]                WA3W,
    output logic                      AlignErrW
);
    localparam int LW = $clog2(LANES);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t                   st_q;
    logic [LW-1:0]            lane_q;
    logic [LANES-1:0][DW-1:0] addr_q, wdata_q, rdata_q, rdata_d;
    logic                     store_q, load_q, rw_q, m2r_q, align_q, align_d;
    logic [3:0]               wa_q;
    logic                     mem_op, mis, adv, last;
    logic [DW-1:0]            cur_addr;

    assign mem_op    = ValidM & (MemWriteM | MemtoRegM);
    assign cur_addr  = addr_q[lane_q];
    assign mis       = |cur_addr[1:0];
    assign adv       = (st_q == ACCESS) & (mis | mem_ready);
    assign last      = lane_q == LW'(LANES - 1);
    assign mem_req   = (st_q == ACCESS) & ~mis;
    assign mem_we    = mem_req & store_q;
    assign mem_addr  = mem_req ? AW'(cur_addr) : '0;
    assign mem_wdata = mem_req ? wdata_q[lane_q] : '0;
    assign StallM    = ((st_q == IDLE) & mem_op) | (st_q == ACCESS);
    assign align_d   = align_q | (adv & mis);

    // Skipped lanes and store lanes leave a zero in the read buffer.
    always_comb begin
        rdata_d = rdata_q;
        if (adv) rdata_d[lane_q] = (load_q & ~mis) ? mem_rdata : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_q      <= IDLE;
            lane_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            store_q   <= 1'b0;
            load_q    <= 1'b0;
            rw_q      <= 1'b0;
            m2r_q     <= 1'b0;
            align_q   <= 1'b0;
            wa_q      <= '0;
            ValidW    <= 1'b0;
            ALUOutW   <= '0;
            ReadDataW <= '0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            WA3W      <= '0;
            AlignErrW <= 1'b0;
        end else begin
            ValidW <= 1'b0;
            case (st_q)
                IDLE: begin
                    if (mem_op) begin
                        st_q    <= ACCESS;
                        lane_q  <= '0;
                        addr_q  <= ALUResultM;
                        wdata_q <= WriteDataM;
                        rdata_q <= '0;
                        align_q <= 1'b0;
                        store_q <= MemWriteM;
                        load_q  <= MemtoRegM & ~MemWriteM;
                        rw_q    <= RegWriteM;
                        m2r_q   <= MemtoRegM;
                        wa_q    <= WA3M;
                    end else if (ValidM) begin
                        ValidW    <= 1'b1;
                        ALUOutW   <= ALUResultM;
                        ReadDataW <= '0;
                        RegWriteW <= RegWriteM;
                        MemtoRegW <= MemtoRegM;
                        WA3W      <= WA3M;
                        AlignErrW <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (adv) begin
                        rdata_q <= rdata_d;
                        align_q <= align_d;
                        lane_q  <= last ? '0 : lane_q + 1'b1;
                        if (last) begin
                            st_q      <= DONE;
                            ValidW    <= 1'b1;
                            ALUOutW   <= addr_q;
                            ReadDataW <= rdata_d;
                            RegWriteW <= rw_q;
                            MemtoRegW <= m2r_q;
                            WA3W      <= wa_q;
                            AlignErrW <= align_d;
                        end
                    end
                end
                default: st_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/vec_mem_stage.md
Name: vec_mem_stage

Overview:
Memory-stage consumer sitting directly after the execute/memory pipeline register of the 16-lane vector datapath. It takes the registered vector op (per-lane addresses, store data, control bits) and serializes 16-lane loads and stores onto a single-port 32-bit data-memory request/ready interface. It stalls the upstream register while an access is in flight, then delivers a one-cycle result beat to the write-back side. Non-memory ops pass through in one cycle with no stall.

Parameters:
LANES, 16, number of vector lanes (counter width = clog2(LANES))
DW, 32, lane data width
AW, 32, byte address width

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
ValidM  in  1  op present from execute/memory register
ALUResultM  in  LANES x DW  per-lane byte address (mem ops) or ALU result (non-mem ops)
WriteDataM  in  LANES x DW  per-lane store data
RegWriteM  in  1  register write enable
MemtoRegM  in  1  load op
MemWriteM  in  1  store op
WA3M  in  4  destination register
StallM  out  1  hold upstream register (combinational)
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  AW  byte address of current lane
mem_wdata  out  DW  store data of current lane
mem_rdata  in  DW  read data, valid when mem_req & mem_ready
mem_ready  in  1  request accepted/completed this cycle
ValidW  out  1  one-cycle result beat
ALUOutW  out  LANES x DW  captured ALUResultM
ReadDataW  out  LANES x DW  load data per lane
RegWriteW  out  1  captured RegWriteM
MemtoRegW  out  1  captured MemtoRegM
WA3W  out  4  captured WA3M
AlignErrW  out  1  at least one lane misaligned in this op

Behaviour:
- Reset (async): state=IDLE, lane counter=0, all W outputs 0 (ValidW=0, ReadDataW=0), mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. Reset mid-access aborts immediately; stores already accepted are not undone.
- Mem op = ValidM & (MemWriteM | MemtoRegM). If both MemWriteM and MemtoRegM set, treated as store (MemWriteM wins), ReadDataW=0.
- States IDLE, ACCESS, DONE.
- IDLE: mem op -> capture all inputs, lane=0, ReadData buffer cleared, AlignErr cleared, -> ACCESS. Non-mem valid op -> capture into W registers, ReadDataW=0, ValidW=1 next cycle, stay IDLE. ValidM=0 -> ValidW=0.
- StallM = (IDLE & mem op) | ACCESS. StallM=0 in DONE, so upstream advances on the DONE edge; op presented during DONE is ignored (it is the already-served op).
- ACCESS: lane L = counter. If captured addr[L][1:0]==0: mem_req=1, mem_we=store, mem_addr=addr[L], mem_wdata=wdata[L]; req/addr/we/wdata stable until mem_ready sampled high. On req & ready: load -> ReadData[L]=mem_rdata; counter+1. Misaligned lane: no request, AlignErr=1, ReadData[L]=0, counter+1 in one cycle.
- After lane LANES-1 completes -> DONE (counter wraps to 0). mem_req=0 in DONE.
- DONE: ValidW=1 for exactly this cycle with captured ALUOutW/RegWriteW/MemtoRegW/WA3W, ReadDataW, AlignErrW; -> IDLE.
- W outputs hold their last values when ValidW=0; consumers qualify with ValidW.
- Latency: mem op with mem_ready tied high: 1 (IDLE accept) + 16 (ACCESS) cycles, ValidW in cycle 18. Non-mem op: ValidW the cycle after presentation. Each mem_ready wait cycle adds one cycle.
- mem_ready while mem_req=0: ignored.

Test Plan:
- Reset: assert RST mid-ACCESS at lane 5 -> same cycle mem_req=0, StallM=0, ValidW=0; after release, IDLE, no further memory traffic.
- Pass-through: ValidM=1, MemWriteM=MemtoRegM=0, ALUResultM lane i=i*3, WA3M=7 -> next cycle ValidW=1, ALUOutW lane i=i*3, WA3W=7, StallM never 1.
- Store, mem_ready=1: addr lane i=0x100+4i, data=0xA0+i -> 16 consecutive writes in order, StallM high 17 cycles, ValidW pulse cycle 18, memory[0x100..0x13C]=0xA0..0xAF.
- Load with wait states: mem_ready low 2 cycles per lane, memory[0x200+4i]=i^0x55 -> addr/we held stable during wait, ReadDataW lane i=i^0x55, ValidW after 1+48 cycles.
- Misaligned: load with lane 3 addr=0x301 -> lane 3 skipped (15 requests), ReadDataW lane 3=0, AlignErrW=1; next aligned op AlignErrW=0.
- Back-to-back: store followed by non-mem op held upstream -> second op not captured during DONE, passes through the cycle after IDLE re-entry, exactly one ValidW per op.
